// File: rtl/vga_timing_gen_if.sv
// Scan-position and sync bundle between the VGA timing generator and its consumers.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic        en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
`ifdef VGA_TIMING_FRAME_CNT_EN
    output frame_cnt,
`endif
    input  en,
    output hcount, vcount, active, line_start, frame_start, hsync, vsync, blank_n
  );

  modport slave (
`ifdef VGA_TIMING_FRAME_CNT_EN
    input  frame_cnt,
`endif
    output en,
    input  hcount, vcount, active, line_start, frame_start, hsync, vsync, blank_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V scan counters, porch/sync FSMs, delayed hsync/vsync/blank_n.
// Optional 16-bit frame counter when VGA_TIMING_FRAME_CNT_EN is defined.
//
// Both FSMs use the same phase encoding:
//   state    | meaning
//   PH_ACT   | visible pixels (H) / visible lines (V)
//   PH_FRONT | front porch
//   PH_SYNC  | sync pulse asserted
//   PH_BACK  | back porch; reset state, last position before wrap
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 1..4");
  end

  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  function automatic phase_e next_phase(phase_e cur, logic [9:0] cnt, logic [9:0] e_act,
                                        logic [9:0] e_fp, logic [9:0] e_sync, logic [9:0] e_last);
    next_phase = cur;
    unique case (cur)
      PH_ACT:   if (cnt == e_act)  next_phase = PH_FRONT;
      PH_FRONT: if (cnt == e_fp)   next_phase = PH_SYNC;
      PH_SYNC:  if (cnt == e_sync) next_phase = PH_BACK;
      PH_BACK:  if (cnt == e_last) next_phase = PH_ACT;
    endcase
  endfunction

  phase_e                h_state_q, h_state_d, v_state_q, v_state_d;
  logic [9:0]            hcount_q, hcount_d, vcount_q, vcount_d;
  logic                  active_q, active_d;
  logic                  line_start_q, line_start_d;
  logic                  frame_start_q, frame_start_d;
  logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, bl_pipe_q, bl_pipe_d;
  logic                  h_wrap, v_wrap, hsync_raw, vsync_raw;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]           frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    hsync_raw     = (h_state_q == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_raw     = (v_state_q == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    active_d      = active_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    bl_pipe_d     = bl_pipe_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (vga.en) begin
      hcount_d  = h_wrap ? '0 : hcount_q + 10'd1;
      h_state_d = next_phase(h_state_q, hcount_q, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST);
      if (h_wrap) begin
        vcount_d  = v_wrap ? '0 : vcount_q + 10'd1;
        v_state_d = next_phase(v_state_q, vcount_q, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST);
      end
      // Registered flags are derived from next state so they stay coincident with the counters.
      active_d      = (h_state_d == PH_ACT) && (v_state_d == PH_ACT);
      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
      hs_pipe_d     = SYNC_DELAY'({hs_pipe_q, hsync_raw});
      vs_pipe_d     = SYNC_DELAY'({vs_pipe_q, vsync_raw});
      bl_pipe_d     = SYNC_DELAY'({bl_pipe_q, active_q});
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (h_wrap && v_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      h_state_q     <= PH_BACK;
      v_state_q     <= PH_BACK;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= {SYNC_DELAY{~HSYNC_POL}};
      vs_pipe_q     <= {SYNC_DELAY{~VSYNC_POL}};
      bl_pipe_q     <= '0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      bl_pipe_q     <= bl_pipe_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.active      = active_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = hs_pipe_q[SYNC_DELAY-1];
  assign vga.vsync       = vs_pipe_q[SYNC_DELAY-1];
  assign vga.blank_n     = bl_pipe_q[SYNC_DELAY-1];
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign vga.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance with directed line/gating/reset checks, plus a reduced-timing
// instance (SYNC_DELAY=2, positive hsync) checked cycle by cycle against a scoreboard model.
module tb_vga_timing_gen;

  localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 3, BHT = BHA + BHF + BHS + BHB;
  localparam int BVA = 6,  BVF = 2, BVS = 2, BVB = 3, BVT = BVA + BVF + BVS + BVB;
  localparam int BSD = 2;
  localparam bit B_HPOL = 1'b1;
  localparam bit B_VPOL = 1'b0;

  logic vga_clk;
  logic rst_a_n, rst_b_n;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  vga_timing_gen u_dut_a (.vga_clk(vga_clk), .reset_n(rst_a_n), .vga(vga_a));

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HSYNC_POL(B_HPOL), .VSYNC_POL(B_VPOL), .SYNC_DELAY(BSD)
  ) u_dut_b (.vga_clk(vga_clk), .reset_n(rst_b_n), .vga(vga_b));

  always #20 vga_clk = ~vga_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] vec_a();
    return {vga_a.hcount, vga_a.vcount, vga_a.active, vga_a.line_start, vga_a.frame_start,
            vga_a.hsync, vga_a.vsync, vga_a.blank_n};
  endfunction

  function automatic logic [25:0] vec_b();
    return {vga_b.hcount, vga_b.vcount, vga_b.active, vga_b.line_start, vga_b.frame_start,
            vga_b.hsync, vga_b.vsync, vga_b.blank_n};
  endfunction

  // Reference model for instance B, driven purely from position arithmetic.
  int          m_h, m_v;
  logic [3:0]  hs_p, vs_p, bl_p;
  logic [15:0] m_fc;
  logic [25:0] sb_q[$];

  task automatic model_reset();
    m_h = BHT - 1; m_v = BVT - 1; m_fc = '0;
    hs_p = {4{~B_HPOL}}; vs_p = {4{~B_VPOL}}; bl_p = '0;
  endtask

  task automatic model_step(input logic en);
    logic hraw, vraw, araw;
    if (!en) return;
    hraw = (m_h >= BHA + BHF && m_h < BHA + BHF + BHS) ? B_HPOL : ~B_HPOL;
    vraw = (m_v >= BVA + BVF && m_v < BVA + BVF + BVS) ? B_VPOL : ~B_VPOL;
    araw = (m_h < BHA) && (m_v < BVA);
    hs_p = {hs_p[2:0], hraw};
    vs_p = {vs_p[2:0], vraw};
    bl_p = {bl_p[2:0], araw};
    if (m_h == BHT - 1) begin
      m_h = 0;
      if (m_v == BVT - 1) begin m_v = 0; m_fc = m_fc + 16'd1; end
      else m_v = m_v + 1;
    end else m_h = m_h + 1;
  endtask

  function automatic logic [25:0] model_vec();
    logic act, ls, fs;
    act = (m_h < BHA) && (m_v < BVA);
    ls  = (m_h == 0);
    fs  = (m_h == 0) && (m_v == 0);
    return {10'(m_h), 10'(m_v), act, ls, fs, hs_p[BSD-1], vs_p[BSD-1], bl_p[BSD-1]};
  endfunction

  // Directed monitors (enabled edges only)
  int   a_per, a_hs_run, a_bl_run, b_fper, b_vs_run;
  bit   a_ls_seen, b_fseen;
  logic a_prev_hs, a_prev_bl, b_prev_vs;

  task automatic mon_reset_a();
    a_per = 0; a_hs_run = 0; a_bl_run = 0; a_ls_seen = 0; a_prev_hs = 1'b1; a_prev_bl = 1'b0;
  endtask

  task automatic mon_reset_b();
    b_fper = 0; b_vs_run = 0; b_fseen = 0; b_prev_vs = 1'b1;
  endtask

  task automatic mon_a();
    a_per++;
    if (vga_a.line_start) begin
      if (a_ls_seen) chk("a_line_period", a_per, 800);
      a_per = 0; a_ls_seen = 1;
    end
    if (!vga_a.hsync) begin
      if (a_prev_hs) chk("a_hs_fall_pos", vga_a.hcount, 657);
      a_hs_run++;
    end else if (!a_prev_hs) begin
      chk("a_hs_width", a_hs_run, 96);
      a_hs_run = 0;
    end
    a_prev_hs = vga_a.hsync;
    if (vga_a.blank_n) a_bl_run++;
    else if (a_prev_bl) begin
      chk("a_blank_width", a_bl_run, 640);
      a_bl_run = 0;
    end
    a_prev_bl = vga_a.blank_n;
  endtask

  task automatic mon_b();
    b_fper++;
    if (vga_b.frame_start) begin
      if (b_fseen) chk("b_frame_period", b_fper, BHT * BVT);
      b_fper = 0; b_fseen = 1;
    end
    if (!vga_b.vsync) begin
      if (b_prev_vs) chk("b_vs_fall_pos", {vga_b.vcount, vga_b.hcount}, {10'd8, 10'd2});
      b_vs_run++;
    end else if (!b_prev_vs) begin
      chk("b_vs_width", b_vs_run, BVS * BHT);
      b_vs_run = 0;
    end
    b_prev_vs = vga_b.vsync;
    if (vga_b.blank_n)
      chk("b_blank_region", 32'(vga_b.hcount >= 10'd2 && vga_b.hcount < 10'd18 && vga_b.vcount < 10'd6), 1);
  endtask

  task automatic tick();
    logic a_on, b_on, b_en;
    logic [25:0] exp;
    a_on = rst_a_n && vga_a.en;
    b_on = rst_b_n;
    b_en = vga_b.en;
    if (b_on) begin
      model_step(b_en);
      sb_q.push_back(model_vec());
    end
    @(posedge vga_clk);
    #1;
    if (a_on) mon_a();
    if (b_on) begin
      exp = sb_q.pop_front();
      chk("b_scoreboard", vec_b(), exp);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("b_frame_cnt", vga_b.frame_cnt, m_fc);
`endif
      if (b_en) mon_b();
    end
    vga_b.en = ($urandom_range(0, 3) != 0);
  endtask

  bit gated = 0;
  bit found;

  initial begin
    vga_clk = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
    vga_a.en = 1'b1; vga_b.en = 1'b1;
    mon_reset_a(); mon_reset_b();
    #5 rst_a_n = 1'b0; rst_b_n = 1'b0;
    model_reset();
    repeat (2) @(posedge vga_clk);
    #1;
    chk("a_reset", vec_a(), {10'd799, 10'd524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("b_reset", vec_b(), model_vec());
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("a_frame_cnt_reset", vga_a.frame_cnt, 0);
`endif
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    tick();
    chk("a_first_pos", vec_a(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("a_frame_cnt_first", vga_a.frame_cnt, 1);
`endif
    tick();
    chk("a_blank_rise", vec_a(), {10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});

    for (int c = 0; c < 2500; c++) begin
      tick();
      if (!gated && vga_a.hcount == 10'd300 && vga_a.vcount == 10'd1) begin
        gated = 1;
        vga_a.en = 1'b0;
        repeat (37) begin
          tick();
          chk("a_frozen", vec_a(), {10'd300, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        vga_a.en = 1'b1;
        tick();
        chk("a_resume", vga_a.hcount, 301);
      end
    end
    chk("a_gate_reached", 32'(gated), 1);

    // Asynchronous reset of A during its hsync pulse
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      tick();
      found = (vga_a.hcount == 10'd700);
    end
    chk("a_wait_700", 32'(found), 1);
    chk("a_hs_active_at_700", vga_a.hsync, 0);
    #5 rst_a_n = 1'b0;
    #1 chk("a_async_rst", vec_a(), {10'd799, 10'd524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    mon_reset_a();
    tick();
    rst_a_n = 1'b1;
    tick();
    chk("a_restart", vec_a(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

    // Asynchronous reset of B while both syncs are asserted
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      found = (vga_b.hsync == B_HPOL) && (vga_b.vsync == B_VPOL);
    end
    chk("b_wait_sync", 32'(found), 1);
    #5 rst_b_n = 1'b0;
    #1 chk("b_async_rst", {vga_b.hsync, vga_b.vsync, vga_b.blank_n, vga_b.hcount, vga_b.vcount},
           {~B_HPOL, ~B_VPOL, 1'b0, 10'd24, 10'd12});
    model_reset();
    sb_q.delete();
    mon_reset_b();
    tick();
    rst_b_n = 1'b1;
    for (int c = 0; c < 400; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA path, clocked by the 25 MHz pixel clock. Produces the `hcount`/`vcount` scan position consumed by the pixel stage (test pattern generator or board renderer). Also produces hsync/vsync/blank, delayed so they line up with that stage's registered RGB at the DAC pins. Frame and line strobes are provided for frame-synchronous logic.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`
- `SYNC_DELAY`, 1, pipeline stages on `hsync`/`vsync`/`blank_n`; legal range 1..4
- `vga_clk` input 1: pixel clock
- `reset_n` input 1: reset, asynchronous, active-low
- `en` input 1: pixel enable; low freezes every register
- `hcount` output 10: horizontal position, 0..H_TOTAL-1
- `vcount` output 10: vertical position, 0..V_TOTAL-1
- `active` output 1: current (`hcount`, `vcount`) lies inside the visible area; undelayed
- `line_start` output 1: high while `hcount`==0
- `frame_start` output 1: high while `hcount`==0 and `vcount`==0
- `hsync` output 1: delayed horizontal sync
- `vsync` output 1: delayed vertical sync
- `blank_n` output 1: delayed `active`; 0 = blank
- `frame_cnt` output 16: frame counter; present only with `VGA_TIMING_FRAME_CNT_EN`

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is the vertical equivalent (525). Both must be ≤1024; out-of-range parameters are an elaboration error.
- Horizontal FSM `H_ACT`→`H_FRONT`→`H_SYNC`→`H_BACK`→`H_ACT`.
  - Transitions occur on `hcount` boundaries: H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1, H_TOTAL-1.
- Vertical FSM `V_ACT`→`V_FRONT`→`V_SYNC`→`V_BACK`→`V_ACT`.
  - Same boundaries on `vcount`.
  - It advances only on the cycle `hcount` wraps H_TOTAL-1→0.
- `hcount` increments by 1 every enabled cycle and wraps to 0 after H_TOTAL-1.
- `vcount` increments when `hcount` wraps, and wraps to 0 after V_TOTAL-1.
- Raw sync: hsync_raw = HSYNC_POL when H state is `H_SYNC`, else the inactive level. vsync_raw is the same from the V state.
- `active` = (H state `H_ACT`) and (V state `V_ACT`). It is equivalent to `hcount`<H_ACTIVE and `vcount`<V_ACTIVE, and the FSM state must always agree with the counters.
- hsync_raw, vsync_raw and `active` each pass through a SYNC_DELAY-deep shift register to form `hsync`, `vsync` and `blank_n`.
- Reset values:
  - `hcount`=H_TOTAL-1 and `vcount`=V_TOTAL-1; both FSMs in their BACK state.
  - `active`=0, `line_start`=0, `frame_start`=0.
  - All pipeline stages at the inactive sync level, with `blank_n`=0.
  - The first enabled edge after release moves to (0,0) and pulses `frame_start`.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). No partial sync pulse may persist past reset assertion.
- `en`=0: counters, FSMs and pipeline all hold; outputs are static. On re-enable, the sequence resumes with no skipped or repeated position.

## Timing
- `hcount`, `vcount`, `active`, `line_start` and `frame_start` are registered and mutually coincident (latency 0 relative to each other).
- `hsync`/`vsync`/`blank_n` for position (h,v) appear SYNC_DELAY enabled cycles after `hcount`=h, `vcount`=v.
  - SYNC_DELAY=1 matches a single-register pixel stage.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL×V_TOTAL = 420000 cycles.
- With defaults:
  - hsync is asserted for 96 cycles, for the positions `hcount` 656..751.
  - vsync is asserted for 2 lines, for the positions `vcount` 490..491.
  - Both edges of vsync are coincident, after the SYNC_DELAY shift, with the `hcount`=0 position.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists; reset value 0.
  - It increments on the same edge that moves counters to (0,0), i.e. the cycle `frame_start` becomes 1.
  - Wraps 65535→0.
  - Holds when `en`=0.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset (defaults): hold `reset_n`=0 → `hcount`=799, `vcount`=524, `hsync`=1, `vsync`=1, `blank_n`=0. First edge after release → (0,0) with `frame_start`=1; next cycle `blank_n`=1.
- Line check: count cycles between `line_start` pulses → 800. `hsync` low exactly 96 cycles, falling one cycle after `hcount`=656. `blank_n` high 640 cycles per visible line.
- Frame check: `frame_start` pulses 420000 cycles apart. `vsync` low for 1600 cycles starting one cycle after (`hcount`=0, `vcount`=490). No `blank_n`=1 for `vcount`≥480.
- Enable gating: drop `en` for 37 cycles at `hcount`=300 → all outputs frozen. On re-enable `hcount` continues 301; line period measured in enabled cycles stays 800.
- Reset mid-frame: assert `reset_n` at `hcount`=700, `vcount`=491 during an active sync → `vsync`/`hsync` go inactive without waiting for a clock; the reset sequence then restarts cleanly.
- With `VGA_TIMING_FRAME_CNT_EN`, SYNC_DELAY=2: 3 frames → `frame_cnt`=3. Preload near wrap via forced run → 65535→0. `hsync` falls two cycles after `hcount`=656.
